// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the ALU op sequencer.
// Opcode values match the ALU encoding; LOADI reuses the spare code 3'b111.
package alu_pkg;

    localparam logic [2:0] OP_MOV   = 3'd0;
    localparam logic [2:0] OP_NOT   = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_OR    = 3'd4;
    localparam logic [2:0] OP_AND   = 3'd5;
    localparam logic [2:0] OP_SLT   = 3'd6;
    localparam logic [2:0] OP_LOADI = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/seq_regfile.sv
// NREGS x N register file: one write port, three combinational reads.
// Every entry, including r0, is an ordinary writable register.
import alu_pkg::*;

module seq_regfile #(
    parameter int N     = 8,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [N-1:0]  wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  rdata1,
    output logic [N-1:0]  rdata2,
    output logic [N-1:0]  dbg_data
);

    logic [N-1:0] mem [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1   = mem[raddr1];
    assign rdata2   = mem[raddr2];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Four-cycle IDLE/READ/EXEC/WB controller around an external shared ALU.
// ALU operands and opcode are registered so nothing from in_* reaches alu_*.
import alu_pkg::*;

module alu_op_sequencer #(
    parameter int N     = 8,
    parameter int NREGS = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs1,
    input  logic [AW-1:0] in_rs2,
    input  logic [N-1:0]  in_imm,
    output logic [N-1:0]  alu_R2,
    output logic [N-1:0]  alu_R3,
    output logic [2:0]    alu_op,
    input  logic [N-1:0]  alu_R1,
    input  logic          alu_c_out,
    input  logic          alu_c_out2,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  done_data,
    output logic          done_carry,
    input  logic [AW-1:0] dbg_addr,
    output logic [N-1:0]  dbg_data
);

    state_t        state;
    state_t        state_n;
    logic [2:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [AW-1:0] rs1_q;
    logic [AW-1:0] rs2_q;
    logic [N-1:0]  imm_q;
    logic [N-1:0]  rdata1;
    logic [N-1:0]  rdata2;
    logic          accept;
    logic          we;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        we       = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_n = S_READ;
                end
            end
            S_READ: state_n = S_EXEC;
            S_EXEC: state_n = S_WB;
            S_WB: begin
                done    = 1'b1;
                we      = 1'b1;
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_MOV;
            rd_q  <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            imm_q <= '0;
        end else if (accept) begin
            op_q  <= in_op;
            rd_q  <= in_rd;
            rs1_q <= in_rs1;
            rs2_q <= in_rs2;
            imm_q <= in_imm;
        end
    end

    // LOADI never uses the ALU result, so park the ALU on MOV.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_R2 <= '0;
            alu_R3 <= '0;
            alu_op <= OP_MOV;
        end else if (state == S_READ) begin
            alu_R2 <= rdata1;
            alu_R3 <= rdata2;
            alu_op <= (op_q == OP_LOADI) ? OP_MOV : op_q;
        end
    end

    // done_data doubles as the write-back value and is visible during WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_data  <= '0;
            done_carry <= 1'b0;
        end else if (state == S_EXEC) begin
            done_data  <= (op_q == OP_LOADI) ? imm_q : alu_R1;
            done_carry <= (op_q == OP_ADD) ? alu_c_out :
                          (op_q == OP_SUB) ? alu_c_out2 : 1'b0;
        end
    end

    seq_regfile #(
        .N     (N),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (rd_q),
        .wdata    (done_data),
        .raddr1   (rs1_q),
        .raddr2   (rs2_q),
        .dbg_addr (dbg_addr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (dbg_data)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU.
// SLT is modelled as an unsigned compare; SUB carry means no borrow.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = 3'd0;
    logic [2:0] in_rd = 3'd0;
    logic [2:0] in_rs1 = 3'd0;
    logic [2:0] in_rs2 = 3'd0;
    logic [7:0] in_imm = 8'd0;
    logic [7:0] alu_R2;
    logic [7:0] alu_R3;
    logic [2:0] alu_op;
    logic [7:0] alu_R1;
    logic       alu_c_out;
    logic       alu_c_out2;
    logic       busy;
    logic       done;
    logic [7:0] done_data;
    logic       done_carry;
    logic [2:0] dbg_addr = 3'd0;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.N(8), .NREGS(8), .AW(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .alu_R2     (alu_R2),
        .alu_R3     (alu_R3),
        .alu_op     (alu_op),
        .alu_R1     (alu_R1),
        .alu_c_out  (alu_c_out),
        .alu_c_out2 (alu_c_out2),
        .busy       (busy),
        .done       (done),
        .done_data  (done_data),
        .done_carry (done_carry),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always_comb begin
        alu_R1     = 8'd0;
        alu_c_out  = 1'b0;
        alu_c_out2 = 1'b0;
        case (alu_op)
            3'd0: alu_R1 = alu_R2;
            3'd1: alu_R1 = ~alu_R2;
            3'd2: {alu_c_out, alu_R1} = {1'b0, alu_R2} + {1'b0, alu_R3};
            3'd3: begin
                alu_R1     = alu_R2 - alu_R3;
                alu_c_out2 = (alu_R2 >= alu_R3);
            end
            3'd4: alu_R1 = alu_R2 | alu_R3;
            3'd5: alu_R1 = alu_R2 & alu_R3;
            3'd6: alu_R1 = {7'd0, (alu_R2 < alu_R3)};
            default: alu_R1 = 8'd0;
        endcase
    end

    // Issues one instruction; returns latency (accept edge to done) or -1.
    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2,
                         input logic [7:0] imm, output int lat,
                         output logic [7:0] d, output logic c);
        int k;
        lat = -1;
        d = 8'hxx;
        c = 1'bx;
        @(negedge clk);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (done) begin
                lat = i;
                d = done_data;
                c = done_carry;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/busy/done=%b%b%b want 100",
                     in_ready, busy, done);
        end
        checks++;
        if (alu_op !== 3'd0 || alu_R2 !== 8'd0 || alu_R3 !== 8'd0 ||
            done_data !== 8'd0 || done_carry !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: op=%h R2=%h R3=%h dd=%h dc=%b want zeros",
                     alu_op, alu_R2, alu_R3, done_data, done_carry);
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            checks++;
            if (dbg_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h want 00", a, dbg_data);
            end
        end
    endtask

    task automatic test_loadi_add();
        int lat; logic [7:0] d; logic c;
        issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h0F, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h0F || c !== 1'b0) begin
            errors++;
            $display("FAIL loadi_r1: lat=%0d d=%h c=%b want 3 0f 0", lat, d, c);
        end
        issue(3'd7, 3'd2, 3'd0, 3'd0, 8'hF1, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'hF1 || c !== 1'b0) begin
            errors++;
            $display("FAIL loadi_r2: lat=%0d d=%h c=%b want 3 f1 0", lat, d, c);
        end
        issue(3'd2, 3'd3, 3'd1, 3'd2, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h00 || c !== 1'b1) begin
            errors++;
            $display("FAIL add_r3: lat=%0d d=%h c=%b want 3 00 1", lat, d, c);
        end
        @(negedge clk);
        dbg_addr = 3'd3;
        #1;
        checks++;
        if (dbg_data !== 8'h00 || done_data !== 8'h00 || done_carry !== 1'b1) begin
            errors++;
            $display("FAIL add_hold: r3=%h dd=%h dc=%b want 00 00 1",
                     dbg_data, done_data, done_carry);
        end
    endtask

    task automatic test_sub();
        int lat; logic [7:0] d; logic c;
        issue(3'd3, 3'd4, 3'd2, 3'd1, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'hE2 || c !== 1'b1) begin
            errors++;
            $display("FAIL sub_r4: lat=%0d d=%h c=%b want 3 e2 1", lat, d, c);
        end
        issue(3'd3, 3'd5, 3'd1, 3'd2, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h1E || c !== 1'b0) begin
            errors++;
            $display("FAIL sub_r5: lat=%0d d=%h c=%b want 3 1e 0", lat, d, c);
        end
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        logic rdy;
        @(negedge clk);
        in_op = 3'd0; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd0;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            rdy = in_ready;
            checks++;
            if (rdy !== (cyc % 4 == 0)) begin
                errors++;
                $display("FAIL b2b_ready_c%0d: got %b want %b",
                         cyc, rdy, (cyc % 4 == 0));
            end
            if (rdy) accepts++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (accepts !== 3) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d want 3", accepts);
        end
        repeat (3) @(negedge clk);
        dbg_addr = 3'd6;
        #1;
        checks++;
        if (dbg_data !== 8'h0F || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_r6: r6=%h rdy=%b want 0f 1", dbg_data, in_ready);
        end
    endtask

    task automatic test_self_and_mov();
        int lat; logic [7:0] d; logic c;
        issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h40, lat, d, c);
        issue(3'd2, 3'd1, 3'd1, 3'd1, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h80 || c !== 1'b0) begin
            errors++;
            $display("FAIL add_self: lat=%0d d=%h c=%b want 3 80 0", lat, d, c);
        end
        issue(3'd0, 3'd6, 3'd2, 3'd0, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'hF1 || c !== 1'b0) begin
            errors++;
            $display("FAIL mov_r6: lat=%0d d=%h c=%b want 3 f1 0", lat, d, c);
        end
    endtask

    task automatic test_logic_ops();
        int lat; logic [7:0] d; logic c;
        issue(3'd7, 3'd1, 3'd0, 3'd0, 8'h0F, lat, d, c);
        issue(3'd6, 3'd7, 3'd1, 3'd2, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h01 || c !== 1'b0) begin
            errors++;
            $display("FAIL slt_r7: lat=%0d d=%h c=%b want 3 01 0", lat, d, c);
        end
        issue(3'd1, 3'd0, 3'd1, 3'd0, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'hF0) begin
            errors++;
            $display("FAIL not_r0: lat=%0d d=%h want 3 f0", lat, d);
        end
        issue(3'd4, 3'd4, 3'd1, 3'd2, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'hFF) begin
            errors++;
            $display("FAIL or_r4: lat=%0d d=%h want 3 ff", lat, d);
        end
        issue(3'd5, 3'd5, 3'd1, 3'd2, 8'h00, lat, d, c);
        checks++;
        if (lat !== 3 || d !== 8'h01) begin
            errors++;
            $display("FAIL and_r5: lat=%0d d=%h want 3 01", lat, d);
        end
        @(negedge clk);
        dbg_addr = 3'd0;
        #1;
        checks++;
        if (dbg_data !== 8'hF0) begin
            errors++;
            $display("FAIL r0_write: got %h want f0", dbg_data);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_done = 1'b0;
        @(negedge clk);
        in_op = 3'd2; in_rd = 3'd3; in_rs1 = 3'd1; in_rs2 = 3'd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_exec: busy=%b done=%b want 1 0", busy, done);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (done) saw_done = 1'b1;
        checks++;
        if (saw_done !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_ctrl: done_seen=%b rdy=%b want 0 1",
                     saw_done, in_ready);
        end
        for (int a = 0; a < 8; a++) begin
            dbg_addr = 3'(a);
            #1;
            checks++;
            if (dbg_data !== 8'd0) begin
                errors++;
                $display("FAIL abort_reg%0d: got %h want 00", a, dbg_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loadi_add();
        test_sub();
        test_back_to_back();
        test_self_and_mov();
        test_logic_ops();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
